// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer for a shared SubBytes/ShiftRows/MixColumns/AddRoundKey datapath.
// Latency: accept at cycle 0, round enables every DP_LATENCY cycles, out_valid at cycle 10*DP_LATENCY+1.
// Backpressure: the finished block is held in DONE with out_valid high until out_ready; in_ready is low meanwhile.
module aes_round_ctrl #(
    // Cycles the round datapath needs before state/key registers may capture; legal range 1..8.
    parameter int DP_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       load_en,
    output logic       state_en,
    output logic       key_en,
    output logic [7:0] rcon,
    output logic [3:0] round_idx,
    output logic       last_round,
    output logic       empty
);

    // Wait counter only needs to reach DP_LATENCY-1; keep it at least one bit wide.
    localparam int                WAIT_W    = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DP_LATENCY - 1);

    localparam logic [3:0] ROUND_FIRST = 4'd1;
    localparam logic [3:0] ROUND_LAST  = 4'd10;
    localparam logic [7:0] RCON_FIRST  = 8'h01;

    // FSM encoding; the fourth code is unreachable and decays to IDLE.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        round_q, round_d;
    logic [7:0]        rcon_q,  rcon_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;

    logic st_idle;
    logic st_round;
    logic st_done;
    logic wait_done;
    logic accept;

    // GF(2^8) doubling with the AES polynomial; generates the Rcon sequence 01..80,1B,36.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    assign st_idle  = (state_q == ST_IDLE);
    assign st_round = (state_q == ST_ROUND);
    assign st_done  = (state_q == ST_DONE);

    // The datapath result is ready for capture on the last cycle of each round's wait window.
    assign wait_done = st_round && (wait_q == WAIT_LAST);

    // A DONE block leaving in the same cycle frees the controller, so a new block can slip in back-to-back.
    assign in_ready = st_idle | (st_done & out_ready);

    // flush wins over a new block: nothing is loaded in the abort cycle.
    assign accept = in_valid & in_ready & ~flush;

    assign load_en    = accept;
    assign state_en   = wait_done & ~flush;
    assign key_en     = wait_done & ~flush;
    assign out_valid  = st_done & ~flush;
    assign last_round = st_round && (round_q == ROUND_LAST);
    assign empty      = st_idle;
    assign rcon       = rcon_q;
    assign round_idx  = round_q;

    // Next-state logic: sequence rounds, hold the result in DONE, and chain straight into a new block when possible.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        wait_d  = wait_q;

        if (flush) begin
            state_d = ST_IDLE;
            round_d = 4'd0;
            rcon_d  = 8'h00;
            wait_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_ROUND;
                        round_d = ROUND_FIRST;
                        rcon_d  = RCON_FIRST;
                        wait_d  = '0;
                    end
                end

                ST_ROUND: begin
                    if (wait_done) begin
                        wait_d = '0;
                        if (round_q == ROUND_LAST) begin
                            // Round index and Rcon stay at 10/36 while the result waits in DONE.
                            state_d = ST_DONE;
                        end else begin
                            round_d = round_q + 4'd1;
                            rcon_d  = xtime(rcon_q);
                        end
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        if (accept) begin
                            state_d = ST_ROUND;
                            round_d = ROUND_FIRST;
                            rcon_d  = RCON_FIRST;
                            wait_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                            round_d = 4'd0;
                            rcon_d  = 8'h00;
                            wait_d  = '0;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    round_d = 4'd0;
                    rcon_d  = 8'h00;
                    wait_d  = '0;
                end
            endcase
        end
    end

    // Sequencer registers; reset drops any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            round_q <= 4'd0;
            rcon_q  <= 8'h00;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: two instances (DP_LATENCY 1 and 3) drive a behavioural AES-128 datapath.
// Latency: checks every cycle of each block against hand-derived enable/Rcon/round schedules.
// Backpressure: exercises DONE hold with out_ready low, back-to-back handoff, flush and async reset.
module tb_aes_round_ctrl;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    localparam logic [7:0] RC [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush     [2];
    logic       in_valid  [2];
    logic       out_ready [2];
    logic       in_ready  [2];
    logic       out_valid [2];
    logic       load_en   [2];
    logic       state_en  [2];
    logic       key_en    [2];
    logic       last_round[2];
    logic       empty     [2];
    logic [7:0] rcon      [2];
    logic [3:0] round_idx [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.DP_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .load_en(load_en[0]), .state_en(state_en[0]), .key_en(key_en[0]),
        .rcon(rcon[0]), .round_idx(round_idx[0]),
        .last_round(last_round[0]), .empty(empty[0])
    );

    aes_round_ctrl #(.DP_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .load_en(load_en[1]), .state_en(state_en[1]), .key_en(key_en[1]),
        .rcon(rcon[1]), .round_idx(round_idx[1]),
        .last_round(last_round[1]), .empty(empty[1])
    );

    // ---------------- behavioural AES-128 round datapath ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(c*4+r) -: 8] = SBOX[gb(s, ((c + r) % 4) * 4 + r)];
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, c*4);   a1 = gb(s, c*4+1);
            a2 = gb(s, c*4+2); a3 = gb(s, c*4+3);
            o[127-8*(c*4)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[127-8*(c*4+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[127-8*(c*4+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[127-8*(c*4+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] t;
        t = sub_shift(s);
        if (!last) t = mix(t);
        return t ^ rk;
    endfunction

    logic [127:0] st0_q, key0_q, st1_q, key1_q;

    // Datapath registers for the DP_LATENCY=1 instance, steered only by the controller strobes.
    always @(posedge clk) begin
        if (load_en[0]) begin
            st0_q  <= PT ^ KEY;
            key0_q <= KEY;
        end else begin
            if (state_en[0]) st0_q  <= aes_round(st0_q, next_key(key0_q, rcon[0]), last_round[0]);
            if (key_en[0])   key0_q <= next_key(key0_q, rcon[0]);
        end
    end

    // Datapath registers for the DP_LATENCY=3 instance.
    always @(posedge clk) begin
        if (load_en[1]) begin
            st1_q  <= PT ^ KEY;
            key1_q <= KEY;
        end else begin
            if (state_en[1]) st1_q  <= aes_round(st1_q, next_key(key1_q, rcon[1]), last_round[1]);
            if (key_en[1])   key1_q <= next_key(key1_q, rcon[1]);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] get_vec(input int d);
        return {load_en[d], state_en[d], key_en[d], last_round[d], out_valid[d],
                in_ready[d], empty[d], round_idx[d], rcon[d]};
    endfunction

    function automatic logic [18:0] mk_vec(input logic ld, input logic se, input logic ke,
                                           input logic lr, input logic ov, input logic ir,
                                           input logic em, input logic [3:0] ri,
                                           input logic [7:0] rc);
        return {ld, se, ke, lr, ov, ir, em, ri, rc};
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset(input int d, input string tag);
        check_eq(tag, 128'(get_vec(d)), 128'(mk_vec(0, 0, 0, 0, 0, 1, 1, 4'd0, 8'h00)));
    endtask

    // Caller keeps in_valid low so an idle controller shows no load strobe.
    task automatic check_idle(input int d, input string tag);
        #1 check_eq(tag, 128'(get_vec(d)), 128'(mk_vec(0, 0, 0, 0, 0, 1, 1, 4'd0, 8'h00)));
    endtask

    // Accept from IDLE in the current cycle; optionally keep in_valid asserted afterwards.
    task automatic accept_blk(input int d, input bit hold);
        in_valid[d] = 1'b1;
        #1 check_eq($sformatf("d%0d_accept", d), 128'(get_vec(d)),
                    128'(mk_vec(1, 0, 0, 0, 0, 1, 1, 4'd0, 8'h00)));
        tick();
        if (!hold) in_valid[d] = 1'b0;
    endtask

    // Cycle c after accept: strobes at multiples of L, Rcon steps after each strobe, last round is the tenth.
    task automatic run_rounds(input int d, input int upto);
        int l;
        l = lat(d);
        for (int c = 1; c <= upto; c++) begin
            #1 check_eq($sformatf("d%0d_c%0d", d, c), 128'(get_vec(d)),
                        128'(mk_vec(0, (c % l) == 0, (c % l) == 0, c > 9 * l, 0, 0, 0,
                                    4'((c - 1) / l + 1), RC[(c - 1) / l])));
            tick();
        end
    endtask

    task automatic check_done(input int d, input string tag);
        #1 check_eq(tag, 128'(get_vec(d)),
                    128'(mk_vec(in_valid[d] & out_ready[d], 0, 0, 0, 1, out_ready[d], 0,
                                4'd10, 8'h36)));
    endtask

    task automatic check_cipher(input int d, input string tag);
        check_eq(tag, (d == 0) ? st0_q : st1_q, CT);
    endtask

    task automatic full_block(input int d, input string tag);
        out_ready[d] = 1'b1;
        accept_blk(d, 1'b0);
        run_rounds(d, 10 * lat(d));
        check_done(d, {tag, "_done"});
        check_cipher(d, {tag, "_ct"});
        tick();
        check_idle(d, {tag, "_idle"});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int d = 0; d < 2; d++) begin
            flush[d]     = 1'b0;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
        end
        #1 rst = 1'b1;
        #1 check_reset(0, "rst_l1");
        check_reset(1, "rst_l3");
        @(negedge clk);
        rst = 1'b0;
        check_idle(0, "post_rst_l1");

        // Single block, latency 1, consumer always ready.
        full_block(0, "blk1");

        // in_valid held through the rounds, then DONE backpressured for five cycles.
        out_ready[0] = 1'b0;
        accept_blk(0, 1'b1);
        run_rounds(0, 10);
        for (int i = 0; i < 5; i++) begin
            check_done(0, $sformatf("bp_hold%0d", i));
            tick();
        end
        // Handshake and a new accept in the same cycle.
        out_ready[0] = 1'b1;
        check_done(0, "bp_handoff");
        check_cipher(0, "bp_ct");
        tick();
        in_valid[0] = 1'b0;
        run_rounds(0, 10);
        check_done(0, "b2b_done");
        check_cipher(0, "b2b_ct");
        tick();
        check_idle(0, "b2b_idle");

        // Flush at round 5 while in_valid is also high.
        accept_blk(0, 1'b0);
        run_rounds(0, 4);
        flush[0]    = 1'b1;
        in_valid[0] = 1'b1;
        #1 check_eq("flush_cycle", 128'(get_vec(0)),
                    128'(mk_vec(0, 0, 0, 0, 0, 0, 0, 4'd5, 8'h10)));
        tick();
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle(0, $sformatf("flush_idle%0d", i));
            tick();
        end
        full_block(0, "post_flush");

        // Latency 3 instance.
        full_block(1, "l3");

        // Asynchronous reset between clock edges, mid-round.
        accept_blk(0, 1'b0);
        run_rounds(0, 2);
        #2 rst = 1'b1;
        #1 check_reset(0, "arst_mid");
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle(0, "arst_idle");
        full_block(0, "post_arst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 round sequencer that drives the shared round datapath (SubBytes → ShiftRows → MixColumns/AddRoundKey/key-expansion XOR stage).
- Accepts one block per in_valid/in_ready handshake and issues the load strobe.
- Walks rounds 1..10: supplies Rcon, enables the state and key registers once per round, and flags the final round so the datapath bypasses MixColumns.
- Presents the result via out_valid/out_ready, and drives the pipeline "empty" flag consumed downstream.

Parameters:
- DP_LATENCY, 1, cycles the round datapath needs per round before state/key registers may capture; legal 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; returns block to IDLE.
- in_valid  in  1  plaintext+key available on datapath inputs.
- in_ready  out  1  controller can accept a block.
- out_valid  out  1  ciphertext valid on datapath state register.
- out_ready  in  1  consumer takes ciphertext.
- load_en  out  1  datapath loads plaintext^key into state reg and key into key reg.
- state_en  out  1  state register captures round output.
- key_en  out  1  key register captures next round key.
- rcon  out  8  round constant to key-expansion XOR.
- round_idx  out  4  current round, 0 when idle.
- last_round  out  1  high while round_idx == 10; datapath bypasses MixColumns.
- empty  out  1  high when no block in flight.

Behaviour:
- Single clock, asynchronous active-high reset; all state flops reset asynchronously.
- States: IDLE, ROUND, DONE.
- Reset values: state=IDLE, round_idx=0, rcon=8'h00, wait_cnt=0. Resulting outputs: in_ready=1, empty=1, out_valid=0, load_en=0, state_en=0, key_en=0, last_round=0.
- in_ready (combinational) = (state==IDLE) | (state==DONE & out_ready).
- Accept = in_valid & in_ready & ~flush.
  - load_en = accept, in the same cycle (combinational).
  - Next cycle: state=ROUND, round_idx=1, rcon=8'h01, wait_cnt=0.
- ROUND:
  - wait_cnt increments each cycle from 0 to DP_LATENCY-1.
  - At wait_cnt==DP_LATENCY-1: state_en=1 and key_en=1 for exactly one cycle; wait_cnt returns to 0.
  - If round_idx==10 → DONE, with round_idx and rcon held.
  - Otherwise round_idx+1 and rcon=xtime(rcon), where xtime = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
  - Required rcon sequence: 01,02,04,08,10,20,40,80,1B,36. The value is 36 exactly when last_round=1.
- last_round = (state==ROUND) & (round_idx==10).
- DONE:
  - out_valid=1, held stable until out_ready; no register enables fire.
  - On out_ready: if accept in the same cycle, go directly to ROUND (round 1) and pulse load_en. Otherwise go to IDLE with round_idx=0, rcon=00.
- empty = (state==IDLE). Goes low the cycle after accept; goes high the cycle after the out handshake unless a new block was accepted.
- Latency with DP_LATENCY=L:
  - Accept at cycle 0.
  - state_en pulses at cycles L, 2L, …, 10L.
  - out_valid first high at cycle 10L+1.
  - Back-to-back throughput: one block per 10L+1 cycles.
- in_valid during ROUND is ignored (in_ready=0); input data is not sampled.
- out_ready while not in DONE has no effect.
- flush (sync, priority over everything except rst): next cycle state=IDLE, round_idx=0, rcon=00, wait_cnt=0. No out_valid, no load_en, no state_en/key_en in the flush cycle.
- rst mid-round: immediate return to reset values; the partial block is discarded.

Test Plan:
- Reset then single block, DP_LATENCY=1, out_ready=1: accept at cycle 0 → state_en/key_en pulse at cycles 1..10; rcon 01,02,04,08,10,20,40,80,1B,36; last_round only at cycle 10; out_valid at cycle 11; empty back to 1 at cycle 12. Ciphertext for FIPS-197 key 000102…0F, plaintext 00112233…FF = 69c4e0d86a7b0430d8cdb78070b4c55a.
- DP_LATENCY=3: state_en at cycles 3,6,…,30; out_valid at cycle 31; rcon constant between pulses.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid stays 1, no enables, in_ready=0, in_valid ignored; then out_ready=1 with in_valid=1 → load_en in that cycle, round_idx=1 next cycle, empty never rises.
- in_valid held high during ROUND → no second load_en until DONE handshake; rcon sequence unperturbed.
- flush asserted at round 5 → next cycle IDLE, round_idx=0, rcon=00, out_valid never asserts; next block completes normally with full rcon sequence.
- Async rst asserted mid-round, between clock edges → outputs immediately at reset values; after release, in_ready=1 and a new block runs correctly.
